systolic_mm_ctrl: RTL and testbench

- Parametrised NxN matrix-multiply sequencer for the output-stationary systolic array core.
- Accepts two NxN operand matrices through a start/ready handshake and latches them.
- Drives them diagonally skewed into the array's row and column edges, waits out the pipeline drain, then captures the result matrix.
- Signals completion with a one-cycle done pulse and returns to idle. Supports back-to-back runs and an accumulate mode that keeps prior partial sums.

---
 rtl/systolic_pkg.sv | 26 ++
 rtl/systolic_mm_ctrl_if.sv | 30 +++
 rtl/skew_feeder.sv | 33 +++
 rtl/systolic_mm_ctrl.sv | 141 ++++++++++++++
 tb/tb_systolic_mm_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic matrix-multiply sequencer.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        STORE = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Cycle counts scale with the array size, so they are provided as functions of N.
    function automatic int feed_cyc(input int n);
        return 2 * n - 1;
    endfunction

    function automatic int drain_cyc(input int n, input int pe_lat);
        return n - 1 + pe_lat;
    endfunction

    function automatic int elem_lsb(input int row, input int col, input int n, input int w);
        return (row * n + col) * w;
    endfunction

endpackage

// File: rtl/systolic_mm_ctrl_if.sv
// Host and array-edge signal bundle of the systolic matrix-multiply sequencer.
interface systolic_mm_ctrl_if #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
);
    logic                    start;
    logic                    acc_mode;
    logic [N*N*DATA_W-1:0]   a_mat;
    logic [N*N*DATA_W-1:0]   b_mat;
    logic                    ready;
    logic                    arr_clr;
    logic [N*DATA_W-1:0]     arr_a;
    logic [N*DATA_W-1:0]     arr_b;
    logic [N*N*ACC_W-1:0]    arr_c;
    logic [N*N*ACC_W-1:0]    c_out;
    logic                    c_valid;
    logic                    done;

    modport master (
        output start, acc_mode, a_mat, b_mat, arr_c,
        input  ready, arr_clr, arr_a, arr_b, c_out, c_valid, done
    );

    modport slave (
        input  start, acc_mode, a_mat, b_mat, arr_c,
        output ready, arr_clr, arr_a, arr_b, c_out, c_valid, done
    );

endinterface

// File: rtl/skew_feeder.sv
// Produces one diagonally skewed lane vector from a latched operand matrix.
module skew_feeder
    import systolic_pkg::*;
#(
    parameter int N        = 4,
    parameter int DATA_W   = 8,
    parameter int STEP_W   = 4,
    parameter bit ROW_MODE = 1'b1
) (
    input  logic [N*N*DATA_W-1:0] i_mat,
    input  logic [STEP_W-1:0]     i_step,
    input  logic                  i_en,
    output logic [N*DATA_W-1:0]   o_lanes
);

    int w_diag;

    // Lane l carries the element whose inner index is step-l; row mode walks A[l][*], column mode B[*][l].
    always_comb begin
        o_lanes = '0;
        w_diag  = 0;
        for (int l = 0; l < N; l++) begin
            w_diag = int'(i_step) - l;
            if (i_en && (w_diag >= 0) && (w_diag < N)) begin
                if (ROW_MODE)
                    o_lanes[l*DATA_W +: DATA_W] = i_mat[elem_lsb(l, w_diag, N, DATA_W) +: DATA_W];
                else
                    o_lanes[l*DATA_W +: DATA_W] = i_mat[elem_lsb(w_diag, l, N, DATA_W) +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/systolic_mm_ctrl.sv
// Sequencer for the output-stationary NxN systolic array: latch, skew-feed, drain, capture.
//   state | meaning
//   IDLE  | ready for start, result held
//   LOAD  | operands latched, array accumulators cleared unless accumulating
//   FEED  | 2N-1 skewed operand steps
//   DRAIN | wait for the last products to reach the far corner
//   STORE | capture arr_c into c_out
//   DONE  | one-cycle completion pulse
module systolic_mm_ctrl
    import systolic_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int PE_LAT = 1
) (
    input  logic               clk,
    input  logic               st_rst_n,
    systolic_mm_ctrl_if.slave  bus
);

    localparam int FEED_CYC  = feed_cyc(N);
    localparam int DRAIN_CYC = drain_cyc(N, PE_LAT);
    localparam int CNT_W     = $clog2(FEED_CYC + DRAIN_CYC + 1);
    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(FEED_CYC - 1);
    localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYC - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [N*N*DATA_W-1:0]   r_a_mat;
    logic [N*N*DATA_W-1:0]   r_b_mat;
    logic [N*DATA_W-1:0]     r_arr_a;
    logic [N*DATA_W-1:0]     r_arr_b;
    logic [N*DATA_W-1:0]     w_lane_a;
    logic [N*DATA_W-1:0]     w_lane_b;
    logic [N*N*ACC_W-1:0]    r_c_out;
    logic                    r_arr_clr;
    logic                    r_done;
    logic                    r_c_valid;
    logic                    w_accept;
    logic                    w_feed_en;

    assign w_accept  = (r_state == IDLE) && bus.start;
    assign w_feed_en = (w_state_nxt == FEED);

    always_ff @(posedge clk) begin
        if (!st_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // FEED counts the skew step up; DRAIN counts down to its terminal zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = LOAD;
                    w_cnt_nxt   = '0;
                end
            end
            LOAD: begin
                w_state_nxt = FEED;
                w_cnt_nxt   = '0;
            end
            FEED: begin
                if (r_cnt == FEED_LAST) begin
                    w_state_nxt = DRAIN;
                    w_cnt_nxt   = DRAIN_INIT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (r_cnt == '0)
                    w_state_nxt = STORE;
                else
                    w_cnt_nxt = r_cnt - CNT_W'(1);
            end
            STORE:   w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    skew_feeder #(
        .N(N), .DATA_W(DATA_W), .STEP_W(CNT_W), .ROW_MODE(1'b1)
    ) u_feed_a (
        .i_mat(r_a_mat), .i_step(w_cnt_nxt), .i_en(w_feed_en), .o_lanes(w_lane_a)
    );

    skew_feeder #(
        .N(N), .DATA_W(DATA_W), .STEP_W(CNT_W), .ROW_MODE(1'b0)
    ) u_feed_b (
        .i_mat(r_b_mat), .i_step(w_cnt_nxt), .i_en(w_feed_en), .o_lanes(w_lane_b)
    );

    // Outputs are registered from next-state values so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (!st_rst_n) begin
            r_a_mat   <= '0;
            r_b_mat   <= '0;
            r_arr_a   <= '0;
            r_arr_b   <= '0;
            r_arr_clr <= 1'b0;
            r_done    <= 1'b0;
            r_c_valid <= 1'b0;
            r_c_out   <= '0;
        end else begin
            r_arr_a   <= w_lane_a;
            r_arr_b   <= w_lane_b;
            r_arr_clr <= w_accept && !bus.acc_mode;
            r_done    <= (r_state == STORE);
            if (w_accept) begin
                r_a_mat   <= bus.a_mat;
                r_b_mat   <= bus.b_mat;
                r_c_valid <= 1'b0;
            end
            if (r_state == STORE) begin
                r_c_out   <= bus.arr_c;
                r_c_valid <= 1'b1;
            end
        end
    end

    assign bus.ready   = (r_state == IDLE);
    assign bus.arr_clr = r_arr_clr;
    assign bus.arr_a   = r_arr_a;
    assign bus.arr_b   = r_arr_b;
    assign bus.c_out   = r_c_out;
    assign bus.c_valid = r_c_valid;
    assign bus.done    = r_done;

endmodule

// File: tb/tb_systolic_mm_ctrl.sv
// Bench for systolic_mm_ctrl: behavioural systolic core plus a plain matrix-multiply reference.
module tb_systolic_mm_ctrl;

    logic clk = 1'b0;
    logic st_rst_n = 1'b0;
    always #5 clk = ~clk;

    systolic_mm_ctrl_if #(.N(4), .DATA_W(8), .ACC_W(16)) bus4 ();
    systolic_mm_ctrl_if #(.N(2), .DATA_W(8), .ACC_W(16)) bus2 ();

    systolic_mm_ctrl #(.N(4), .DATA_W(8), .ACC_W(16), .PE_LAT(1)) dut4 (
        .clk(clk), .st_rst_n(st_rst_n), .bus(bus4)
    );
    systolic_mm_ctrl #(.N(2), .DATA_W(8), .ACC_W(16), .PE_LAT(1)) dut2 (
        .clk(clk), .st_rst_n(st_rst_n), .bus(bus2)
    );

    // Behavioural output-stationary cores: operands hop one PE per cycle, products accumulate in place.
    logic [15:0] acc4 [4][4];
    logic [7:0]  ah4  [4][4];
    logic [7:0]  bv4  [4][4];
    logic [15:0] acc2 [2][2];
    logic [7:0]  ah2  [2][2];
    logic [7:0]  bv2  [2][2];

    function automatic logic [7:0] a_in4(input int i, input int j);
        if (j == 0) return bus4.arr_a[i*8 +: 8];
        return ah4[i][j-1];
    endfunction
    function automatic logic [7:0] b_in4(input int i, input int j);
        if (i == 0) return bus4.arr_b[j*8 +: 8];
        return bv4[i-1][j];
    endfunction
    function automatic logic [7:0] a_in2(input int i, input int j);
        if (j == 0) return bus2.arr_a[i*8 +: 8];
        return ah2[i][j-1];
    endfunction
    function automatic logic [7:0] b_in2(input int i, input int j);
        if (i == 0) return bus2.arr_b[j*8 +: 8];
        return bv2[i-1][j];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                if (!st_rst_n) begin
                    acc4[i][j] <= 16'd0; ah4[i][j] <= 8'd0; bv4[i][j] <= 8'd0;
                end else begin
                    acc4[i][j] <= (bus4.arr_clr ? 16'd0 : acc4[i][j]) + 16'(a_in4(i, j)) * 16'(b_in4(i, j));
                    ah4[i][j]  <= a_in4(i, j);
                    bv4[i][j]  <= b_in4(i, j);
                end
            end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                if (!st_rst_n) begin
                    acc2[i][j] <= 16'd0; ah2[i][j] <= 8'd0; bv2[i][j] <= 8'd0;
                end else begin
                    acc2[i][j] <= (bus2.arr_clr ? 16'd0 : acc2[i][j]) + 16'(a_in2(i, j)) * 16'(b_in2(i, j));
                    ah2[i][j]  <= a_in2(i, j);
                    bv2[i][j]  <= b_in2(i, j);
                end
            end
    end

    always_comb begin
        bus4.arr_c = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                bus4.arr_c[(i*4+j)*16 +: 16] = acc4[i][j];
    end
    always_comb begin
        bus2.arr_c = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                bus2.arr_c[(i*2+j)*16 +: 16] = acc2[i][j];
    end

    int n_checks = 0;
    int n_fail   = 0;

    int ma [4][4];
    int mb [4][4];
    int model_c [4][4];

    logic [31:0]  tr_a    [48];
    logic [31:0]  tr_b    [48];
    logic         tr_clr  [48];
    logic         tr_done [48];
    logic         tr_rdy  [48];
    logic         tr_cv   [48];
    logic [255:0] tr_c    [48];

    function automatic logic [127:0] pack_op(input int m [4][4]);
        logic [127:0] p;
        p = '0;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++)
                p[(i*4+k)*8 +: 8] = 8'(m[i][k]);
        return p;
    endfunction

    function automatic logic [255:0] pack_res(input int m [4][4]);
        logic [255:0] p;
        p = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                p[(i*4+j)*16 +: 16] = 16'(m[i][j]);
        return p;
    endfunction

    // Reference: C = A*B (+ previous C when accumulating), wrapped to 16 bits.
    task automatic model_mm(input bit accm);
        int s;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                s = accm ? model_c[i][j] : 0;
                for (int k = 0; k < 4; k++)
                    s += ma[i][k] * mb[k][j];
                model_c[i][j] = s & 32'hFFFF;
            end
    endtask

    function automatic int first_done(input int kmax);
        for (int k = 0; k < kmax; k++)
            if (tr_done[k] === 1'b1) return k;
        return -1;
    endfunction

    function automatic int count_done(input int kmax);
        int c;
        c = 0;
        for (int k = 0; k < kmax; k++)
            if (tr_done[k] === 1'b1) c++;
        return c;
    endfunction

    // Sample k is taken at the falling edge after posedge e0+k (e0 = the accepting edge).
    task automatic run4(input bit accm, input int hold_k, input int kmax,
                        input int chg_k, input logic [127:0] alt_a);
        @(negedge clk);
        bus4.a_mat    = pack_op(ma);
        bus4.b_mat    = pack_op(mb);
        bus4.acc_mode = accm;
        bus4.start    = 1'b1;
        for (int k = 0; k < kmax; k++) begin
            @(negedge clk);
            tr_a[k]    = bus4.arr_a;
            tr_b[k]    = bus4.arr_b;
            tr_clr[k]  = bus4.arr_clr;
            tr_done[k] = bus4.done;
            tr_rdy[k]  = bus4.ready;
            tr_cv[k]   = bus4.c_valid;
            tr_c[k]    = bus4.c_out;
            if (k == hold_k) bus4.start = 1'b0;
            if (k == chg_k) bus4.a_mat = alt_a;
        end
    endtask

    task automatic set_plan_operands();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ma[i][k] = i*4 + k + 1;
                mb[i][k] = i*4 + k + 17;
            end
    endtask

    task automatic test_reset();
        st_rst_n = 1'b0;
        bus4.start = 1'b0; bus4.acc_mode = 1'b0; bus4.a_mat = '0; bus4.b_mat = '0;
        bus2.start = 1'b0; bus2.acc_mode = 1'b0; bus2.a_mat = '0; bus2.b_mat = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus4.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", bus4.ready); end
        n_checks++; if (bus4.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus4.done); end
        n_checks++; if (bus4.c_valid !== 1'b0) begin n_fail++; $display("FAIL reset_c_valid got %b want 0", bus4.c_valid); end
        n_checks++; if (bus4.c_out !== 256'd0) begin n_fail++; $display("FAIL reset_c_out got %0h want 0", bus4.c_out); end
        n_checks++; if (bus4.arr_a !== 32'd0 || bus4.arr_b !== 32'd0) begin n_fail++; $display("FAIL reset_arr got a=%0h b=%0h want 0", bus4.arr_a, bus4.arr_b); end
        n_checks++; if (bus4.arr_clr !== 1'b0) begin n_fail++; $display("FAIL reset_arr_clr got %b want 0", bus4.arr_clr); end
        n_checks++; if (bus2.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_n2 got %b want 1", bus2.ready); end
        st_rst_n = 1'b1;
    endtask

    task automatic test_basic();
        set_plan_operands();
        model_mm(1'b0);
        run4(1'b0, 0, 16, -1, '0);
        n_checks++; if (first_done(16) !== 13) begin n_fail++; $display("FAIL basic_done_cycle got %0d want 13", first_done(16)); end
        n_checks++; if (count_done(16) !== 1) begin n_fail++; $display("FAIL basic_done_count got %0d want 1", count_done(16)); end
        n_checks++; if (tr_c[14][15:0] !== 16'd250) begin n_fail++; $display("FAIL basic_c00 got %0d want 250", tr_c[14][15:0]); end
        n_checks++; if (tr_c[14][3*16 +: 16] !== 16'd280) begin n_fail++; $display("FAIL basic_c03 got %0d want 280", tr_c[14][3*16 +: 16]); end
        n_checks++; if (tr_c[14][15*16 +: 16] !== 16'd1528) begin n_fail++; $display("FAIL basic_c33 got %0d want 1528", tr_c[14][15*16 +: 16]); end
        n_checks++; if (tr_c[14] !== pack_res(model_c)) begin n_fail++; $display("FAIL basic_c_full got %0h want %0h", tr_c[14], pack_res(model_c)); end
        n_checks++; if (tr_cv[12] !== 1'b0 || tr_cv[13] !== 1'b1) begin n_fail++; $display("FAIL basic_c_valid got k12=%b k13=%b want 0,1", tr_cv[12], tr_cv[13]); end
        for (int k = 0; k < 15; k++) begin
            n_checks++;
            if (tr_rdy[k] !== (k == 14)) begin n_fail++; $display("FAIL basic_ready k=%0d got %b want %b", k, tr_rdy[k], k == 14); end
        end
    endtask

    task automatic test_feed();
        logic [31:0] ea, eb;
        int t, d;
        n_checks++; if (tr_a[1] !== 32'h0000_0001 || tr_b[1] !== 32'h0000_0011) begin n_fail++; $display("FAIL feed_t0 got a=%0h b=%0h want 1,11", tr_a[1], tr_b[1]); end
        n_checks++; if (tr_a[2][7:0] !== 8'd2 || tr_a[2][15:8] !== 8'd5) begin n_fail++; $display("FAIL feed_t1 got lane0=%0d lane1=%0d want 2,5", tr_a[2][7:0], tr_a[2][15:8]); end
        n_checks++; if (tr_a[7] !== 32'h1000_0000 || tr_b[7] !== 32'h2000_0000) begin n_fail++; $display("FAIL feed_t6 got a=%0h b=%0h want 10000000,20000000", tr_a[7], tr_b[7]); end
        for (int k = 0; k < 16; k++) begin
            ea = '0; eb = '0;
            t = k - 1;
            if (t >= 0 && t <= 6)
                for (int l = 0; l < 4; l++) begin
                    d = t - l;
                    if (d >= 0 && d < 4) begin
                        ea[l*8 +: 8] = 8'(ma[l][d]);
                        eb[l*8 +: 8] = 8'(mb[d][l]);
                    end
                end
            n_checks++;
            if (tr_a[k] !== ea || tr_b[k] !== eb) begin
                n_fail++; $display("FAIL feed_lanes k=%0d got a=%0h b=%0h want a=%0h b=%0h", k, tr_a[k], tr_b[k], ea, eb);
            end
            n_checks++;
            if (tr_clr[k] !== (k == 0)) begin n_fail++; $display("FAIL feed_arr_clr k=%0d got %b want %b", k, tr_clr[k], k == 0); end
        end
    endtask

    task automatic test_accumulate();
        model_mm(1'b1);
        run4(1'b1, 0, 16, -1, '0);
        n_checks++; if (count_done(16) !== 0 && count_done(16) !== 1) begin n_fail++; end
        n_checks++; if (first_done(16) !== 13) begin n_fail++; $display("FAIL acc_done_cycle got %0d want 13", first_done(16)); end
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (tr_clr[k] !== 1'b0) begin n_fail++; $display("FAIL acc_arr_clr k=%0d got %b want 0", k, tr_clr[k]); end
        end
        n_checks++; if (tr_c[14][15:0] !== 16'd500) begin n_fail++; $display("FAIL acc_c00 got %0d want 500", tr_c[14][15:0]); end
        n_checks++; if (tr_c[14][15*16 +: 16] !== 16'd3056) begin n_fail++; $display("FAIL acc_c33 got %0d want 3056", tr_c[14][15*16 +: 16]); end
        n_checks++; if (tr_c[14] !== pack_res(model_c)) begin n_fail++; $display("FAIL acc_c_full got %0h want %0h", tr_c[14], pack_res(model_c)); end
    endtask

    task automatic test_random();
        bit accm;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++)
                for (int k = 0; k < 4; k++) begin
                    ma[i][k] = int'($urandom_range(0, 255));
                    mb[i][k] = int'($urandom_range(0, 255));
                end
            accm = 1'($urandom_range(0, 1));
            model_mm(accm);
            run4(accm, 0, 16, -1, '0);
            n_checks++; if (first_done(16) !== 13) begin n_fail++; $display("FAIL rand_done_cycle run=%0d got %0d want 13", r, first_done(16)); end
            n_checks++; if (tr_c[14] !== pack_res(model_c)) begin n_fail++; $display("FAIL rand_c run=%0d acc=%0d got %0h want %0h", r, accm, tr_c[14], pack_res(model_c)); end
            n_checks++; if (tr_clr[0] !== !accm) begin n_fail++; $display("FAIL rand_arr_clr run=%0d got %b want %b", r, tr_clr[0], !accm); end
        end
    endtask

    task automatic test_back_to_back();
        int alt [4][4];
        set_plan_operands();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++)
                alt[i][k] = int'($urandom_range(0, 255));
        model_mm(1'b0);
        run4(1'b0, 20, 32, 3, pack_op(alt));
        n_checks++; if (tr_c[14] !== pack_res(model_c)) begin n_fail++; $display("FAIL b2b_first_c got %0h want %0h", tr_c[14], pack_res(model_c)); end
        n_checks++; if (count_done(32) !== 2) begin n_fail++; $display("FAIL b2b_done_count got %0d want 2", count_done(32)); end
        n_checks++; if (tr_done[13] !== 1'b1 || tr_done[28] !== 1'b1) begin n_fail++; $display("FAIL b2b_done_cycles got k13=%b k28=%b want 1,1", tr_done[13], tr_done[28]); end
        n_checks++; if (tr_rdy[14] !== 1'b1 || tr_rdy[15] !== 1'b0) begin n_fail++; $display("FAIL b2b_ready got k14=%b k15=%b want 1,0", tr_rdy[14], tr_rdy[15]); end
        n_checks++; if (tr_clr[15] !== 1'b1) begin n_fail++; $display("FAIL b2b_second_clr got %b want 1", tr_clr[15]); end
        for (int k = 1; k < 14; k++) begin
            n_checks++;
            if (tr_rdy[k] !== 1'b0) begin n_fail++; $display("FAIL b2b_busy k=%0d got ready=%b want 0", k, tr_rdy[k]); end
        end
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++)
                ma[i][k] = alt[i][k];
        model_mm(1'b0);
        n_checks++; if (tr_c[29] !== pack_res(model_c)) begin n_fail++; $display("FAIL b2b_second_c got %0h want %0h", tr_c[29], pack_res(model_c)); end
        n_checks++; if (tr_cv[15] !== 1'b0 || tr_cv[29] !== 1'b1) begin n_fail++; $display("FAIL b2b_c_valid got k15=%b k29=%b want 0,1", tr_cv[15], tr_cv[29]); end
    endtask

    task automatic test_reset_midrun();
        int dones;
        set_plan_operands();
        @(negedge clk);
        bus4.a_mat = pack_op(ma); bus4.b_mat = pack_op(mb); bus4.acc_mode = 1'b0; bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus4.arr_a[7:0] !== 8'd3) begin n_fail++; $display("FAIL midrun_feed_step2 got %0d want 3", bus4.arr_a[7:0]); end
        st_rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (bus4.ready !== 1'b1 || bus4.done !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_ctl got ready=%b done=%b want 1,0", bus4.ready, bus4.done); end
        n_checks++; if (bus4.c_valid !== 1'b0 || bus4.c_out !== 256'd0) begin n_fail++; $display("FAIL midrun_reset_result got cv=%b c=%0h want 0,0", bus4.c_valid, bus4.c_out); end
        n_checks++; if (bus4.arr_a !== 32'd0 || bus4.arr_b !== 32'd0 || bus4.arr_clr !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_arr got a=%0h b=%0h clr=%b want 0", bus4.arr_a, bus4.arr_b, bus4.arr_clr); end
        st_rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus4.done === 1'b1) dones++;
        end
        n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL midrun_no_done got %0d pulses want 0", dones); end
        model_mm(1'b0);
        run4(1'b0, 0, 16, -1, '0);
        n_checks++; if (first_done(16) !== 13) begin n_fail++; $display("FAIL midrun_clean_done got %0d want 13", first_done(16)); end
        n_checks++; if (tr_c[14][15:0] !== 16'd250 || tr_c[14] !== pack_res(model_c)) begin n_fail++; $display("FAIL midrun_clean_c got %0h want %0h", tr_c[14], pack_res(model_c)); end
    endtask

    task automatic test_n2();
        int a2 [2][2];
        int b2 [2][2];
        logic [63:0] exp_c;
        logic [63:0] c_at8;
        int fd, nd, s;
        logic cv7;
        a2[0][0] = 3; a2[0][1] = 4; a2[1][0] = 5; a2[1][1] = 6;
        b2[0][0] = 1; b2[0][1] = 0; b2[1][0] = 0; b2[1][1] = 1;
        exp_c = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                s = 0;
                for (int k = 0; k < 2; k++) s += a2[i][k] * b2[k][j];
                exp_c[(i*2+j)*16 +: 16] = 16'(s);
            end
        @(negedge clk);
        bus2.a_mat = '0; bus2.b_mat = '0;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 2; k++) begin
                bus2.a_mat[(i*2+k)*8 +: 8] = 8'(a2[i][k]);
                bus2.b_mat[(i*2+k)*8 +: 8] = 8'(b2[i][k]);
            end
        bus2.acc_mode = 1'b0;
        bus2.start = 1'b1;
        fd = -1; nd = 0; cv7 = 1'b0; c_at8 = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) bus2.start = 1'b0;
            if (bus2.done === 1'b1) begin
                nd++;
                if (fd < 0) fd = k;
            end
            if (k == 7) cv7 = bus2.c_valid;
            if (k == 8) c_at8 = bus2.c_out;
        end
        n_checks++; if (fd !== 7) begin n_fail++; $display("FAIL n2_done_cycle got %0d want 7", fd); end
        n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL n2_done_count got %0d want 1", nd); end
        n_checks++; if (cv7 !== 1'b1) begin n_fail++; $display("FAIL n2_c_valid got %b want 1", cv7); end
        n_checks++; if (c_at8 !== exp_c) begin n_fail++; $display("FAIL n2_c_out got %0h want %0h", c_at8, exp_c); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_feed();
        test_accumulate();
        test_random();
        test_back_to_back();
        test_reset_midrun();
        test_n2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
